// File: rtl/pl_mem_wb.sv
// MEM/WB pipeline stage: lane-parallel RNS data memory, writeback register
// and architectural branch flags.
module pl_mem_wb #(
  parameter int NUM_DOMAINS = 1,
  parameter int DMEM_DEPTH  = 256
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [0:6]               EX_reg,
  input  logic [NUM_DOMAINS*8-1:0] operation_result,
  input  logic [2:0]               destination_reg_addr,
  input  logic [7:0]               data_wr_addr,
  input  logic [7:0]               data_rd_addr,
  input  logic [0:4]               branch_conds_EX,
  output logic                     wb_en,
  output logic [2:0]               wb_addr,
  output logic [NUM_DOMAINS*8-1:0] wb_data,
  output logic [0:3]               flags,
  output logic                     mem_busy_store
);

  localparam int DW = NUM_DOMAINS * 8;
  localparam int AW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

  logic          store_to_mem;
  logic          reg_wr_en;
  logic          save_cout;
  logic          instr_valid;
  logic          load_true;
  logic          cmp_true;
  logic          store_commit;
  logic          unused_ex;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] wb_data_nxt;

  logic [DW-1:0] mem [DMEM_DEPTH];

  assign store_to_mem = EX_reg[0];
  assign reg_wr_en    = EX_reg[1];
  assign save_cout    = EX_reg[2];
  assign instr_valid  = !EX_reg[3];
  assign load_true    = EX_reg[4];
  assign cmp_true     = branch_conds_EX[4];
  assign unused_ex    = ^EX_reg[5:6];

  assign store_commit = store_to_mem && instr_valid && !reset;

  assign wr_idx = AW'(32'(data_wr_addr) % DMEM_DEPTH);
  assign rd_idx = AW'(32'(data_rd_addr) % DMEM_DEPTH);

  // Write-first: a store landing on the read address this edge is forwarded
  always_comb begin
    rd_data = mem[rd_idx];
    if (store_commit && (wr_idx == rd_idx)) begin
      rd_data = operation_result;
    end
  end

  always_comb begin
    wb_data_nxt = operation_result;
    if (load_true) begin
      wb_data_nxt = rd_data;
    end
  end

  // Memory has no reset; contents survive a reset pulse
  always_ff @(posedge clk) begin
    if (store_commit) begin
      mem[wr_idx] <= operation_result;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_en          <= 1'b0;
      wb_addr        <= 3'd0;
      wb_data        <= '0;
      mem_busy_store <= 1'b0;
    end else begin
      wb_en          <= reg_wr_en && instr_valid;
      wb_addr        <= destination_reg_addr;
      wb_data        <= wb_data_nxt;
      mem_busy_store <= store_commit;
    end
  end

  // Compare and carry-save update disjoint flag fields independently
  always_ff @(posedge clk) begin
    if (reset) begin
      flags <= 4'b0000;
    end else begin
      if (cmp_true && instr_valid) begin
        flags[0:2] <= branch_conds_EX[0:2];
      end
      if (save_cout && instr_valid) begin
        flags[3] <= branch_conds_EX[3];
      end
    end
  end

endmodule

// File: doc/pl_mem_wb.md
PL_MEM_WB -- requirements
Module: PL_MEM_WB

Interface
REQ-001 SHALL have parameter NUM_DOMAINS, default 1, number of 8-bit RNS domain lanes per data word.
REQ-002 SHALL have parameter DMEM_DEPTH, default 256, data memory words (address 8 bits).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port EX_reg  input  [0:6]  {store_to_mem, reg_wr_en, save_cout, invalidate_execute_instr, load_true, invalidate_fetch_instr, invalidate_decode_instr}.
REQ-006 SHALL have port operation_result  input  NUM_DOMAINS*8  EX result / store data, {Domain1, Domain2, ...}.
REQ-007 SHALL have port destination_reg_addr  input  3  regfile destination.
REQ-008 SHALL have port data_wr_addr  input  8  store address.
REQ-009 SHALL have port data_rd_addr  input  8  load address.
REQ-010 SHALL have port branch_conds_EX  input  [0:4]  {gt, lt, eq, carry, compare_true}.
REQ-011 SHALL have port wb_en  output  1  regfile write enable.
REQ-012 SHALL have port wb_addr  output  3  regfile write address.
REQ-013 SHALL have port wb_data  output  NUM_DOMAINS*8  regfile write data.
REQ-014 SHALL have port flags  output  [0:3]  architectural {gt, lt, eq, carry} for jump evaluation.
REQ-015 SHALL have port mem_busy_store  output  1  a store committed on the last edge (debug/verification).

Function
REQ-016 SHALL define instr_valid = !EX_reg[3]; an invalid instruction causes no memory write, no register write and no flag change.
REQ-017 SHALL hold a DMEM_DEPTH x NUM_DOMAINS*8 data memory, all lanes written/read together.
REQ-018 SHALL write mem[data_wr_addr] <= operation_result at the edge where EX_reg[0] && instr_valid && !reset; latency 1 edge.
REQ-019 SHALL read mem[data_rd_addr] synchronously every edge; same-edge write to the same address SHALL return the newly written data (write-first).
REQ-020 SHALL register wb_en <= EX_reg[1] && instr_valid, wb_addr <= destination_reg_addr at each edge; writeback outputs valid 1 cycle after EX outputs.
REQ-021 SHALL set wb_data <= read data when EX_reg[4] (load_true), else operation_result, on the same edge.
REQ-022 SHALL update flags[0:2] <= branch_conds_EX[0:2] only when branch_conds_EX[4] && instr_valid; otherwise hold.
REQ-023 SHALL update flags[3] <= branch_conds_EX[3] only when EX_reg[2] && instr_valid; otherwise hold.
REQ-024 SHALL, when compare and save_cout both qualify on one edge, apply both updates independently.
REQ-025 SHALL set mem_busy_store <= store-commit condition of REQ-018, cleared otherwise.
REQ-026 SHALL wrap addresses modulo DMEM_DEPTH; addresses 0 and 255 fully usable.
REQ-027 SHALL ignore EX_reg[5:6]; invalidation of later stages is decided upstream.
REQ-028 SHALL support back-to-back store then load to the same address: load on the following edge returns stored data.

Reset
REQ-029 SHALL, on an edge with reset=1, force wb_en=0, wb_addr=0, wb_data=0, flags=4'b0000, mem_busy_store=0.
REQ-030 SHALL give reset priority over a simultaneous store; that store is dropped.
REQ-031 SHALL leave data memory contents unchanged by reset.
REQ-032 SHALL resume normal operation on the first edge with reset=0; no in-flight state survives reset.

Verification
REQ-033 SHALL cover: store 0x5A to addr 0x10, next cycle load addr 0x10 to r3 -> wb_en=1, wb_addr=3, wb_data=0x5A one cycle after load.
REQ-034 SHALL cover: ALU result 0x81, reg_wr_en=1, dest r7, invalidate=1 -> wb_en=0, no flag change, memory unchanged.
REQ-035 SHALL cover: compare with conds {1,0,0,x,1} then non-compare -> flags[0:2]=100 held until next valid compare.
REQ-036 SHALL cover: add with save_cout=1, carry=1 -> flags[3]=1; later add with save_cout=0, carry=0 -> flags[3] stays 1.
REQ-037 SHALL cover: store 0xFF to addr 0xFF with reset=1 same edge -> mem[0xFF] unchanged, all outputs 0.
REQ-038 SHALL cover: NUM_DOMAINS=2, store 0x1234 to addr 0x00 then load -> wb_data=0x1234, both lanes intact.
